// File: rtl/seq_decoder_pkg.sv
// Shared types and helpers for the seq_decoder registered one-hot decoder.
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } seq_dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    localparam int unsigned MAX_IN_W  = 8;
    localparam int unsigned MAX_OUT_W = 256;

    // One-hot of code, forced to zero when the code is outside 0..out_w-1.
    function automatic logic [MAX_OUT_W-1:0] onehot_f(
        input logic [MAX_IN_W-1:0] code,
        input int unsigned         out_w
    );
        logic [MAX_OUT_W-1:0] v;
        v = {MAX_OUT_W{1'b0}};
        if ({24'd0, code} < out_w) begin
            v[code] = 1'b1;
        end else begin
            v = {MAX_OUT_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_decoder_sweep_gen.sv
// Sweep code generator: up/down code counter, final-code detect and inter-beat gap counter.
module seq_decoder_sweep_gen
    import seq_decoder_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 16,
    parameter int SWEEP_GAP = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_dir,
    input  logic            i_step,
    output logic [IN_W-1:0] o_cnt,
    output logic            o_exhausted,
    output logic            o_gap_zero
);

    localparam logic [IN_W-1:0] LP_TOP  = IN_W'(OUT_W - 1);
    localparam logic [IN_W-1:0] LP_ZERO = {IN_W{1'b0}};
    localparam logic [IN_W-1:0] LP_ONE  = IN_W'(1);
    localparam logic [7:0]      LP_GAP  = 8'(SWEEP_GAP);

    logic [IN_W-1:0] r_cnt;
    logic            r_dir;
    logic            r_exhausted;
    logic [7:0]      r_gap;
    logic            w_last;

    assign w_last      = r_dir ? (r_cnt == LP_TOP) : (r_cnt == LP_ZERO);
    assign o_cnt       = r_cnt;
    assign o_exhausted = r_exhausted;
    assign o_gap_zero  = (r_gap == 8'd0);

    // Counter holds at the final code instead of wrapping; exhausted marks it as already issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= LP_ZERO;
            r_dir       <= 1'b0;
            r_exhausted <= 1'b0;
            r_gap       <= 8'd0;
        end else if (i_start) begin
            r_cnt       <= i_dir ? LP_ZERO : LP_TOP;
            r_dir       <= i_dir;
            r_exhausted <= 1'b0;
            r_gap       <= 8'd0;
        end else if (i_step) begin
            r_gap <= LP_GAP;
            if (w_last) begin
                r_exhausted <= 1'b1;
            end else if (r_dir) begin
                r_cnt <= r_cnt + LP_ONE;
            end else begin
                r_cnt <= r_cnt - LP_ONE;
            end
        end else if (r_gap != 8'd0) begin
            r_gap <= r_gap - 8'd1;
        end else begin
            r_gap <= r_gap;
        end
    end

endmodule

// File: rtl/seq_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready handshakes and a built-in code sweep.
// Optional sticky range_err output is enabled by defining SEQ_DECODER_RANGE_ERR_EN.
module seq_decoder
    import seq_decoder_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 16,
    parameter int SWEEP_GAP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  data_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enable,
    input  logic             mode,
    input  logic             sweep_start,
    input  logic             sweep_dir,
    output logic [OUT_W-1:0] data_out,
    output logic [IN_W-1:0]  code_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sweep_busy,
    output logic             sweep_done
`ifdef SEQ_DECODER_RANGE_ERR_EN
    ,
    output logic             range_err
`endif
);

    if (IN_W < 1 || IN_W > 8 || OUT_W < 1 || OUT_W > (1 << IN_W) ||
        SWEEP_GAP < 0 || SWEEP_GAP > 255) begin : g_param_err
        $error("seq_decoder: illegal IN_W/OUT_W/SWEEP_GAP combination");
    end

    seq_dec_state_t   r_state;
    logic [OUT_W-1:0] r_data_out;
    logic [IN_W-1:0]  r_code_out;
    logic             r_out_valid;
    logic             r_sweep_busy;
    logic             r_sweep_done;

    logic             w_free;
    logic             w_in_ready;
    logic             w_dir_acc;
    logic             w_sweep_start;
    logic             w_sweep_load;
    logic             w_final_acc;
    logic [IN_W-1:0]  w_cnt;
    logic             w_exhausted;
    logic             w_gap_zero;
    logic [OUT_W-1:0] w_dir_onehot;
    logic [OUT_W-1:0] w_sw_onehot;

    // The output register is free when empty or when its beat leaves this cycle.
    assign w_free        = !r_out_valid || out_ready;
    assign w_in_ready    = (r_state == IDLE) && (mode == MODE_DIRECT) && w_free;
    assign w_dir_acc     = in_valid && w_in_ready;
    assign w_sweep_start = (r_state == IDLE) && (mode == MODE_SWEEP) && sweep_start;
    assign w_sweep_load  = (r_state == SWEEP) && w_free && w_gap_zero && !w_exhausted;
    assign w_final_acc   = (r_state == SWEEP) && w_exhausted && r_out_valid && out_ready;

    assign w_dir_onehot = OUT_W'(onehot_f(MAX_IN_W'(data_in), OUT_W));
    assign w_sw_onehot  = OUT_W'(onehot_f(MAX_IN_W'(w_cnt), OUT_W));

    seq_decoder_sweep_gen #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .SWEEP_GAP (SWEEP_GAP)
    ) u_sweep_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_sweep_start),
        .i_dir       (sweep_dir),
        .i_step      (w_sweep_load),
        .o_cnt       (w_cnt),
        .o_exhausted (w_exhausted),
        .o_gap_zero  (w_gap_zero)
    );

    // Control FSM with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sweep_busy <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sweep_done <= 1'b0;
                    if (w_sweep_start) begin
                        r_state      <= SWEEP;
                        r_sweep_busy <= 1'b1;
                    end else begin
                        r_state      <= IDLE;
                        r_sweep_busy <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (w_final_acc) begin
                        r_state      <= DONE;
                        r_sweep_busy <= 1'b0;
                        r_sweep_done <= 1'b1;
                    end else begin
                        r_state      <= SWEEP;
                        r_sweep_busy <= 1'b1;
                        r_sweep_done <= 1'b0;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_sweep_busy <= 1'b0;
                    r_sweep_done <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_sweep_busy <= 1'b0;
                    r_sweep_done <= 1'b0;
                end
            endcase
        end
    end

    // One-deep output register; data and code hold while a beat is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_out  <= {OUT_W{1'b0}};
            r_code_out  <= {IN_W{1'b0}};
            r_out_valid <= 1'b0;
        end else if (w_dir_acc) begin
            r_data_out  <= enable ? w_dir_onehot : {OUT_W{1'b0}};
            r_code_out  <= data_in;
            r_out_valid <= 1'b1;
        end else if (w_sweep_load) begin
            r_data_out  <= enable ? w_sw_onehot : {OUT_W{1'b0}};
            r_code_out  <= w_cnt;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready   = w_in_ready;
    assign data_out   = r_data_out;
    assign code_out   = r_code_out;
    assign out_valid  = r_out_valid;
    assign sweep_busy = r_sweep_busy;
    assign sweep_done = r_sweep_done;

`ifdef SEQ_DECODER_RANGE_ERR_EN
    localparam logic [IN_W:0] LP_OUT_W = (IN_W + 1)'(OUT_W);
    logic r_range_err;

    // Sticky flag: only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (w_dir_acc && ({1'b0, data_in} >= LP_OUT_W)) begin
            r_range_err <= 1'b1;
        end else begin
            r_range_err <= r_range_err;
        end
    end

    assign range_err = r_range_err;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder (truncated 4-to-10 build with a sweep gap of 2).
`timescale 1ns/1ps
module tb_seq_decoder;

    localparam int IN_W  = 4;
    localparam int OUT_W = 10;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  data_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             enable = 1'b1;
    logic             mode = 1'b0;
    logic             sweep_start = 1'b0;
    logic             sweep_dir = 1'b0;
    logic [OUT_W-1:0] data_out;
    logic [IN_W-1:0]  code_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             sweep_busy;
    logic             sweep_done;
`ifdef SEQ_DECODER_RANGE_ERR_EN
    logic             range_err;
`endif

    always #5 clk = ~clk;

    seq_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .SWEEP_GAP(GAP)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .enable      (enable),
        .mode        (mode),
        .sweep_start (sweep_start),
        .sweep_dir   (sweep_dir),
        .data_out    (data_out),
        .code_out    (code_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done)
`ifdef SEQ_DECODER_RANGE_ERR_EN
        ,
        .range_err   (range_err)
`endif
    );

    typedef struct packed {
        logic [IN_W-1:0]  code;
        logic [OUT_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    pops = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    last_acc_cyc = -1;
    int    prev_acc = -1;
    bit    chk_gap = 1'b0;
    bit    model_rerr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference decode: a single set bit at position code, nothing when disabled or out of range.
    function automatic logic [OUT_W-1:0] model_data(input int code, input bit en);
        if (en && code < OUT_W) return OUT_W'(1 << code);
        return '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every beat taken downstream is popped from the scoreboard and compared.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid && out_ready) begin
            check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("code_out", 32'(code_out), 32'(e.code));
                check("data_out", 32'(data_out), 32'(e.data));
                pops++;
                if (chk_gap) begin
                    if (prev_acc >= 0) check("sweep_spacing", 32'(cyc - prev_acc), 32'(GAP + 1));
                    prev_acc = cyc;
                end
                last_acc_cyc = cyc;
            end
        end
        if (rst_n && sweep_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; mode = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_code_out", 32'(code_out), 32'd0);
        check("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
`ifdef SEQ_DECODER_RANGE_ERR_EN
        check("rst_range_err", 32'(range_err), 32'd0);
`endif
        exp_q.delete();
        model_rerr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic direct_send(input int code, input bit en, input bit rnd_ready);
        bit sent = 1'b0;
        data_in = IN_W'(code); enable = en; in_valid = 1'b1;
        for (int k = 0; k < 60 && !sent; k++) begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (in_ready) begin
                exp_q.push_back(beat_t'{code: IN_W'(code), data: model_data(code, en)});
                if (code >= OUT_W) model_rerr = 1'b1;
                sent = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!sent) check("direct_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_sweep(input bit dir, input bit en, input int abort_after);
        int p0;
        int d0;
        bit ok;
        out_ready = 1'b1; enable = en; mode = 1'b1; sweep_dir = dir; sweep_start = 1'b1;
        in_valid = 1'b1; data_in = IN_W'(1);
        for (int i = 0; i < OUT_W; i++) begin
            int c = dir ? i : OUT_W - 1 - i;
            exp_q.push_back(beat_t'{code: IN_W'(c), data: model_data(c, en)});
        end
        p0 = pops; d0 = done_cnt; chk_gap = 1'b1; prev_acc = -1;
        @(negedge clk);
        check("sweep_start_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        sweep_start = 1'b0; in_valid = 1'b0; mode = 1'b0;
        @(negedge clk);
        check("sweep_busy", 32'(sweep_busy), 32'd1);
        check("sweep_in_ready", 32'(in_ready), 32'd0);
        if (abort_after > 0) begin
            ok = 1'b0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(posedge clk); #1;
                ok = (pops - p0 >= abort_after);
            end
            check("abort_reached", 32'(ok), 32'd1);
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("abort_out_valid", 32'(out_valid), 32'd0);
            check("abort_sweep_busy", 32'(sweep_busy), 32'd0);
            check("abort_data_out", 32'(data_out), 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1; exp_q.delete(); model_rerr = 1'b0;
            repeat (30) @(posedge clk);
            #1;
            check("abort_no_done", 32'(done_cnt), 32'(d0));
            check("abort_idle_valid", 32'(out_valid), 32'd0);
        end else begin
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(posedge clk); #1;
                ok = (done_cnt != d0);
            end
            check("sweep_done_seen", 32'(ok), 32'd1);
            check("sweep_beats", 32'(pops - p0), 32'(OUT_W));
            check("sweep_done_timing", 32'(done_cyc), 32'(last_acc_cyc + 1));
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("sweep_done_once", 32'(done_cnt), 32'(d0 + 1));
            check("post_sweep_busy", 32'(sweep_busy), 32'd0);
            check("post_sweep_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        chk_gap = 1'b0;
    endtask

    initial begin
        int t0;
        do_reset();
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Full-throughput direct decode, top code down to zero.
        @(posedge clk); #1;
        t0 = cyc;
        for (int c = OUT_W - 1; c >= 0; c--) direct_send(c, 1'b1, 1'b0);
        check("throughput", 32'(cyc - t0), 32'(OUT_W));

        // Out-of-range codes decode to zero; optional sticky error.
        for (int c = OUT_W; c < (1 << IN_W); c++) direct_send(c, 1'b1, 1'b0);
        direct_send(2, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
`ifdef SEQ_DECODER_RANGE_ERR_EN
        check("range_err_sticky", 32'(range_err), 32'(model_rerr));
`endif

        // Backpressure hold and release.
        direct_send(3, 1'b1, 1'b0);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(data_out), 32'(model_data(3, 1'b1)));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Randomized direct traffic with random enable and downstream stalls.
        for (int i = 0; i < 40; i++) begin
            direct_send(int'($urandom_range(0, (1 << IN_W) - 1)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("direct_drained", 32'(exp_q.size()), 32'd0);

        run_sweep(1'b0, 1'b1, 0);
        run_sweep(1'b1, 1'b0, 0);
        run_sweep(1'b1, 1'b1, 7);

        direct_send(5, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on input and output. It generalises the combinational 4-to-16 decoder to any input width and any output count up to 2**IN_W, including truncated forms such as 4-to-10. A built-in sweep mode walks every legal code up or down and emits one beat per code, replacing hand-written stimulus sequences for downstream blocks.

Parameters:
IN_W, 4, input code width in bits; legal range 1..8.
OUT_W, 16, number of one-hot outputs; must satisfy 1 <= OUT_W <= 2**IN_W, checked by an elaboration-time assertion.
SWEEP_GAP, 0, idle cycles inserted after each accepted sweep beat; legal range 0..255.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
data_in  in  IN_W  binary code in direct mode
in_valid  in  1  data_in is valid
in_ready  out  1  block accepts data_in this cycle
enable  in  1  0 forces data_out to all zeros; handshakes still complete
mode  in  1  0 = direct, 1 = sweep; sampled only in IDLE
sweep_start  in  1  single-cycle request to begin a sweep
sweep_dir  in  1  0 = descend from OUT_W-1 to 0; 1 = ascend from 0 to OUT_W-1; sampled with sweep_start
data_out  out  OUT_W  registered one-hot result
code_out  out  IN_W  registered binary code that produced data_out
out_valid  out  1  data_out and code_out are valid
out_ready  in  1  downstream accepts the current beat
sweep_busy  out  1  high in SWEEP state
sweep_done  out  1  one-cycle pulse after the last sweep beat is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-sweep: state=IDLE; data_out=0, code_out=0, out_valid=0, sweep_busy=0, sweep_done=0; sweep counter and gap counter cleared.
- Output register, one deep: in_ready = (state==IDLE) && (mode==0) && (!out_valid || out_ready).
- Direct accept: in_valid && in_ready. On the next cycle out_valid=1, code_out=data_in, data_out=(1<<data_in). Latency is 1 cycle. Full throughput when out_ready is held at 1.
- Out of range: data_in >= OUT_W gives data_out all zeros; code_out still equals data_in.
- enable=0 at accept time: data_out=0 and code_out=data_in.
- Hold: while out_valid && !out_ready, data_out, code_out and out_valid stay stable.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when mode==1 && sweep_start.
  - Counter loads OUT_W-1 when sweep_dir=0, or 0 when sweep_dir=1.
- SWEEP:
  - A beat is loaded into the output register whenever the register is free and gap_cnt==0.
  - The beat is code_out=cnt and data_out=(1<<cnt), gated by enable.
  - On a loaded beat, cnt steps by -1 or +1 and gap_cnt loads SWEEP_GAP.
  - gap_cnt decrements each cycle while it is nonzero.
  - in_ready=0 throughout. sweep_start and mode changes are ignored.
- SWEEP -> DONE when the final code (0 descending, OUT_W-1 ascending) is accepted downstream (out_valid && out_ready).
- DONE: sweep_done=1 for exactly one cycle, then IDLE. The counter never wraps.
- Simultaneous events:
  - sweep_start with in_valid in IDLE and mode=1: only the sweep starts, because in_ready=0 when mode=1.
  - Reset takes priority over every other event.

Optional Feature:
Macro SEQ_DECODER_RANGE_ERR_EN.
- Defined: adds output port range_err (1 bit), a sticky flag set on any direct accept with data_in >= OUT_W. Only rst_n clears it. Reset value is 0.
- Undefined: the port and its logic are absent; out-of-range codes silently decode to all zeros.

Decomposition:
- Package seq_decoder_pkg holds:
  - typedef enum logic [1:0] {IDLE, SWEEP, DONE} seq_dec_state_t
  - mode constants MODE_DIRECT=1'b0 and MODE_SWEEP=1'b1
  - function onehot_f(code, out_w) returning the gated one-hot value
- Sub-module seq_decoder_sweep_gen holds the up/down code counter, the last-code detect and the gap counter. The top level holds the FSM, the output register and the handshakes.

Test Plan:
- Direct, defaults, out_ready=1: drive data_in 15 down to 0 on consecutive cycles -> one cycle later data_out=16'h8000, 16'h4000, ..., 16'h0001; throughput 1 beat/cycle.
- Truncated OUT_W=10: direct data_in=9 -> data_out=10'h200; data_in=12 -> data_out=0, code_out=12; with SEQ_DECODER_RANGE_ERR_EN, range_err=1 and stays 1 until rst_n=0.
- Backpressure: hold out_ready=0 for 5 cycles after accepting data_in=3 -> data_out=16'h0008 stable, in_ready=0; release -> beat accepted, in_ready=1 the same cycle.
- Sweep descending, SWEEP_GAP=2, out_ready=1: sweep_start, sweep_dir=0 -> 16 beats with code_out 15..0 spaced 3 cycles apart; sweep_done pulses once 1 cycle after code 0 is accepted; then IDLE.
- Sweep ascending, enable=0: beats carry code_out 0..15 with data_out=0 on every beat.
- Reset mid-sweep: assert rst_n=0 at beat 7 -> next cycle out_valid=0, sweep_busy=0, data_out=0, and no sweep_done pulse.
